// File: rtl/sw_debounce_pkg.sv
// Shared constants for the switch conditioner; also mirrored in the firmware register map.
package sw_debounce_pkg;

    localparam int   CLK_HZ           = 12_000_000;
    localparam int   DEF_DEB_CYCLES   = 12_000;     // 1 ms at CLK_HZ
    localparam int   DEF_CNT_W        = 16;
    localparam logic DEF_INIT_LEVEL   = 1'b1;       // pull-up: idle switch reads high

endpackage

// File: rtl/sw_debounce_chan.sv
// One switch channel: 2-FF synchroniser, stability counter, debounced level and edge pulses.
module sw_debounce_chan
    import sw_debounce_pkg::*;
#(
    parameter int   CNT_W      = DEF_CNT_W,
    parameter int   DEB_CYCLES = DEF_DEB_CYCLES,
    parameter logic INIT_LEVEL = DEF_INIT_LEVEL
) (
    input  logic clk,
    input  logic reset,
    input  logic sw_raw,
    output logic sw_state,
    output logic sw_rise,
    output logic sw_fall
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

    logic             s1_q, s2_q;
    logic             state_q, state_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Any sample matching the accepted level restarts the stability window.
    always_comb begin
        cnt_d   = cnt_q;
        state_d = state_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (s2_q == state_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d   = '0;
            state_d = s2_q;
            rise_d  = s2_q;
            fall_d  = ~s2_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q    <= INIT_LEVEL;
            s2_q    <= INIT_LEVEL;
            state_q <= INIT_LEVEL;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            s1_q    <= sw_raw;
            s2_q    <= s1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign sw_state = state_q;
    assign sw_rise  = rise_q;
    assign sw_fall  = fall_q;

endmodule

// File: rtl/sw_debounce.sv
// Board switch conditioner: per-channel debounce plus sticky pending flags and one level IRQ.
module sw_debounce
    import sw_debounce_pkg::*;
#(
    parameter int   N_IN        = 4,
    parameter int   CNT_W       = DEF_CNT_W,
    parameter int   DEB_CYCLES  = DEF_DEB_CYCLES,
    parameter logic INIT_LEVEL  = DEF_INIT_LEVEL,
    parameter bit   IRQ_ON_FALL = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_IN-1:0] sw_raw,
    output logic [N_IN-1:0] sw_state,
    output logic [N_IN-1:0] sw_rise,
    output logic [N_IN-1:0] sw_fall,
    input  logic [N_IN-1:0] irq_mask,
    input  logic [N_IN-1:0] irq_clr,
    output logic [N_IN-1:0] irq_pend,
    output logic            irq
);

    logic [N_IN-1:0] evt;
    logic [N_IN-1:0] pend_q, pend_d;
    logic            irq_q, irq_d;

    for (genvar i = 0; i < N_IN; i++) begin : g_chan
        sw_debounce_chan #(
            .CNT_W      (CNT_W),
            .DEB_CYCLES (DEB_CYCLES),
            .INIT_LEVEL (INIT_LEVEL)
        ) u_chan (
            .clk      (clk),
            .reset    (reset),
            .sw_raw   (sw_raw[i]),
            .sw_state (sw_state[i]),
            .sw_rise  (sw_rise[i]),
            .sw_fall  (sw_fall[i])
        );
    end

    assign evt = IRQ_ON_FALL ? sw_fall : sw_rise;

    // A new edge beats a simultaneous clear so no press is ever lost.
    always_comb begin
        pend_d = (pend_q & ~irq_clr) | evt;
        irq_d  = |(pend_q & irq_mask);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            irq_q  <= irq_d;
        end
    end

    assign irq_pend = pend_q;
    assign irq      = irq_q;

endmodule
